// File: rtl/sparc_pkg.sv
// Shared definitions for the SPARC-subset execution cluster.
// Covers ALU opcodes, register-file geometry and the window mapping.
package sparc_pkg;

  localparam int unsigned NWIN     = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NGLOB    = 8;
  localparam int unsigned WIN_REGS = 16;
  localparam int unsigned NREG     = NGLOB + NWIN * WIN_REGS;
  localparam int unsigned PIDX_W   = $clog2(NREG);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_AND   = 6'h01;
  localparam logic [5:0] OP_OR    = 6'h02;
  localparam logic [5:0] OP_XOR   = 6'h03;
  localparam logic [5:0] OP_SUB   = 6'h04;
  localparam logic [5:0] OP_ANDN  = 6'h05;
  localparam logic [5:0] OP_ORN   = 6'h06;
  localparam logic [5:0] OP_XNOR  = 6'h07;
  localparam logic [5:0] OP_ADDX  = 6'h08;
  localparam logic [5:0] OP_SUBX  = 6'h0C;
  localparam logic [5:0] OP_CC_LO = 6'h10;
  localparam logic [5:0] OP_CC_HI = 6'h1C;
  localparam logic [5:0] OP_SLL   = 6'h25;
  localparam logic [5:0] OP_SRL   = 6'h26;
  localparam logic [5:0] OP_SRA   = 6'h27;

  // Globals map 1:1; windowed registers rotate by 16 per window, wrapping mod 64.
  function automatic logic [PIDX_W-1:0] phys_idx(input logic [4:0] r, input logic [1:0] cwp);
    logic [5:0] off;
    off = 6'(r - 5'd8) + {cwp, 4'b0000};
    if (r < 5'd8) phys_idx = PIDX_W'(r);
    else          phys_idx = PIDX_W'(NGLOB) + PIDX_W'(off);
  endfunction

endpackage

// File: rtl/window_regfile.sv
// Windowed register file: 8 globals plus overlapping windows.
// Combinational reads, synchronous write, synchronous reset clears all entries.
module window_regfile
  import sparc_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned CWPW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CWPW-1:0] cwp,
  input  logic [4:0]      ra,
  input  logic [4:0]      rb,
  input  logic [4:0]      rc,
  input  logic            we_n,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   a_out_c,
  output logic [DW-1:0]   b_out_c
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (!we_n && rc != 5'd0) mem_d[phys_idx(rc, cwp)] = wdata;
  end

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign a_out_c = (ra == 5'd0) ? '0 : mem_q[phys_idx(ra, cwp)];
  assign b_out_c = (rb == 5'd0) ? '0 : mem_q[phys_idx(rb, cwp)];

endmodule

// File: rtl/alu_regfile_tbadd.sv
// Execution datapath cluster: combinational ALU with NZVC flags,
// windowed register file and trap-base address adder.
module alu_regfile_tbadd
  import sparc_pkg::*;
#(
  parameter int unsigned NWIN = 4,
  parameter int unsigned DW   = 32
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [DW-1:0]           A_in,
  input  logic [DW-1:0]           B_in,
  input  logic [5:0]              opcode,
  input  logic                    carry,
  input  logic                    ALUE,
  output logic [DW-1:0]           result,
  output logic                    N,
  output logic                    Z,
  output logic                    V,
  output logic                    C,
  input  logic [DW-1:0]           Rin,
  input  logic [$clog2(NWIN)-1:0] CWP,
  input  logic [4:0]              RA,
  input  logic [4:0]              RB,
  input  logic [4:0]              RC,
  input  logic                    RFE,
  output logic [DW-1:0]           Aout,
  output logic [DW-1:0]           Bout,
  input  logic [DW-1:0]           tb_x,
  input  logic                    TB_ADD,
  output logic [DW-1:0]           tb_out
);

  localparam int unsigned CWPW = $clog2(NWIN);

  logic [5:0]    op;
  logic [DW:0]   uns;
  logic [DW-1:0] res;
  logic          arith, sub, use_cy, cy, v, c;

  window_regfile #(.DW(DW), .CWPW(CWPW)) u_rf (
    .clk     (Clk),
    .rst     (Rst),
    .cwp     (CWP),
    .ra      (RA),
    .rb      (RB),
    .rc      (RC),
    .we_n    (RFE),
    .wdata   (Rin),
    .a_out_c (Aout),
    .b_out_c (Bout)
  );

  // ALU: cc variants share the base datapath; unknown codes pass B through.
  always_comb begin
    op     = opcode;
    uns    = '0;
    res    = B_in;
    arith  = 1'b0;
    sub    = 1'b0;
    use_cy = 1'b0;
    cy     = 1'b0;
    v      = 1'b0;
    c      = 1'b0;
    if (opcode >= OP_CC_LO && opcode <= OP_CC_HI) op = {2'b00, opcode[3:0]};
    case (op)
      OP_ADD:  arith = 1'b1;
      OP_ADDX: begin arith = 1'b1; use_cy = 1'b1; end
      OP_SUB:  begin arith = 1'b1; sub = 1'b1; end
      OP_SUBX: begin arith = 1'b1; sub = 1'b1; use_cy = 1'b1; end
      OP_AND:  res = A_in & B_in;
      OP_OR:   res = A_in | B_in;
      OP_XOR:  res = A_in ^ B_in;
      OP_ANDN: res = A_in & ~B_in;
      OP_ORN:  res = A_in | ~B_in;
      OP_XNOR: res = ~(A_in ^ B_in);
      OP_SLL:  res = A_in << B_in[4:0];
      OP_SRL:  res = A_in >> B_in[4:0];
      OP_SRA:  res = $signed(A_in) >>> B_in[4:0];
      default: res = B_in;
    endcase
    cy = use_cy & carry;
    // Top bit of the widened sum is carry-out for add and borrow for subtract.
    if (sub) uns = {1'b0, A_in} - {1'b0, B_in} - (DW+1)'(cy);
    else     uns = {1'b0, A_in} + {1'b0, B_in} + (DW+1)'(cy);
    if (arith) begin
      res = uns[DW-1:0];
      c   = uns[DW];
      if (sub) v = (A_in[DW-1] != B_in[DW-1]) && (res[DW-1] != A_in[DW-1]);
      else     v = (A_in[DW-1] == B_in[DW-1]) && (res[DW-1] != A_in[DW-1]);
    end
    result = res;
    N      = res[DW-1];
    Z      = (res == '0);
    V      = v;
    C      = c;
    if (ALUE) begin
      result = '0;
      N      = 1'b0;
      Z      = 1'b0;
      V      = 1'b0;
      C      = 1'b0;
    end
  end

  assign tb_out = TB_ADD ? (tb_x & ~DW'(4'hF)) : '0;

endmodule

// File: tb/tb_alu_regfile_tbadd.sv
// Scoreboard bench for alu_regfile_tbadd: directed cases plus random traffic
// checked against a window-level behavioural model.
module tb_alu_regfile_tbadd;

  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] A_in, B_in, Rin, tb_x;
  logic [5:0]  opcode;
  logic        carry, ALUE, RFE, TB_ADD;
  logic [1:0]  CWP;
  logic [4:0]  RA, RB, RC;
  logic [31:0] result, Aout, Bout, tb_out;
  logic        N, Z, V, C;

  always #5 Clk = ~Clk;

  alu_regfile_tbadd #(.NWIN(4), .DW(32)) dut (
    .Clk(Clk), .Rst(Rst), .A_in(A_in), .B_in(B_in), .opcode(opcode),
    .carry(carry), .ALUE(ALUE), .result(result), .N(N), .Z(Z), .V(V), .C(C),
    .Rin(Rin), .CWP(CWP), .RA(RA), .RB(RB), .RC(RC), .RFE(RFE),
    .Aout(Aout), .Bout(Bout), .tb_x(tb_x), .TB_ADD(TB_ADD), .tb_out(tb_out)
  );

  typedef struct {
    logic [31:0] result;
    logic        n, z, v, c;
    logic [31:0] aout, bout, tbo;
  } exp_t;

  typedef struct {
    logic [31:0] a, b, rin, tbx;
    logic [5:0]  op;
    logic        cy, alue, rfe, tbadd, rst;
    logic [1:0]  cwp;
    logic [4:0]  ra, rb, rc;
  } stim_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: globals, plus per window its outs (r8-15) and locals (r16-23);
  // a window's ins are the outs of the next window.
  bit [31:0] glob [8];
  bit [31:0] ol   [4][16];

  function automatic bit [31:0] rf_rd(input int r, input int w);
    if (r == 0)      return 32'h0;
    else if (r < 8)  return glob[r];
    else if (r < 24) return ol[w][r-8];
    else             return ol[(w+1)%4][r-24];
  endfunction

  task automatic rf_wr(input int r, input int w, input bit [31:0] val);
    if (r == 0)      return;
    else if (r < 8)  glob[r] = val;
    else if (r < 24) ol[w][r-8] = val;
    else             ol[(w+1)%4][r-24] = val;
  endtask

  task automatic rf_clear();
    foreach (glob[i]) glob[i] = '0;
    foreach (ol[i, j]) ol[i][j] = '0;
  endtask

  task automatic alu_ref(input bit [31:0] a, input bit [31:0] b, input bit [5:0] op,
                         input bit cy, input bit alue, output exp_t e);
    int              base, ia, ib;
    longint          sa, sb, s, ci;
    longint unsigned ua, ub, u, cu;
    bit [31:0]       r;
    bit [4:0]        sh;
    base = int'(op);
    if (base >= 16 && base <= 28) base = base - 16;
    ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b; sh = b[4:0];
    ci = (base == 8 || base == 12) ? longint'(cy) : 0;
    cu = (base == 8 || base == 12) ? longint'(cy) : 0;
    e.v = 1'b0; e.c = 1'b0;
    case (base)
      0, 8: begin
        u = ua + ub + cu; s = sa + sb + ci; r = u[31:0];
        e.c = (u > 64'hFFFF_FFFF); e.v = (s > SMAX) || (s < SMIN);
      end
      4, 12: begin
        s = sa - sb - ci; r = a - b - 32'(cu);
        e.c = (ua < ub + cu); e.v = (s > SMAX) || (s < SMIN);
      end
      1:  r = a & b;
      2:  r = a | b;
      3:  r = a ^ b;
      5:  r = a & ~b;
      6:  r = a | ~b;
      7:  r = ~(a ^ b);
      37: r = a << sh;
      38: r = a >> sh;
      39: r = ia >>> sh;
      default: r = b;
    endcase
    e.result = r; e.n = r[31]; e.z = (r == 0);
    if (alue) begin
      e.result = '0; e.n = 0; e.z = 0; e.v = 0; e.c = 0;
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.a = '0; s.b = '0; s.rin = '0; s.tbx = '0; s.op = '0;
    s.cy = 0; s.alue = 1; s.rfe = 1; s.tbadd = 0; s.rst = 0;
    s.cwp = '0; s.ra = '0; s.rb = '0; s.rc = '0;
    return s;
  endfunction

  // Drive one cycle; expectation reflects state before this cycle's edge.
  task automatic apply(input stim_t s, input bit chk);
    exp_t e;
    A_in = s.a; B_in = s.b; opcode = s.op; carry = s.cy; ALUE = s.alue;
    Rin = s.rin; CWP = s.cwp; RA = s.ra; RB = s.rb; RC = s.rc; RFE = s.rfe;
    tb_x = s.tbx; TB_ADD = s.tbadd; Rst = s.rst;
    if (chk) begin
      alu_ref(s.a, s.b, s.op, s.cy, s.alue, e);
      e.aout = rf_rd(int'(s.ra), int'(s.cwp));
      e.bout = rf_rd(int'(s.rb), int'(s.cwp));
      e.tbo  = s.tbadd ? (s.tbx / 16) * 16 : 32'h0;
      sbq.push_back(e);
    end
    @(posedge Clk);
    if (s.rst) rf_clear();
    else if (!s.rfe) rf_wr(int'(s.rc), int'(s.cwp), s.rin);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("result", result, e.result);
        check("N", 32'(N), 32'(e.n));
        check("Z", 32'(Z), 32'(e.z));
        check("V", 32'(V), 32'(e.v));
        check("C", 32'(C), 32'(e.c));
        check("Aout", Aout, e.aout);
        check("Bout", Bout, e.bout);
        check("tb_out", tb_out, e.tbo);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    bit [31:0] corner [4];
    corner[0] = 32'h7FFF_FFFF; corner[1] = 32'h8000_0000;
    corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h0000_0000;
    rf_clear();

    s = idle(); s.rst = 1;
    apply(s, 0); apply(s, 0);
    s = idle(); s.ra = 5'd1; s.rb = 5'd31; s.cwp = 2'd2;
    apply(s, 1);

    // ALU corner cases
    s = idle(); s.alue = 0;
    s.op = 6'h00; s.a = 32'h7FFF_FFFF; s.b = 32'd1; apply(s, 1);
    s.op = 6'h04; s.a = 32'd5; s.b = 32'd5;          apply(s, 1);
    s.a = 32'd0; s.b = 32'd1;                        apply(s, 1);
    s.op = 6'h14;                                    apply(s, 1);
    s.alue = 1;                                      apply(s, 1);
    s.alue = 0; s.op = 6'h08; s.a = 32'hFFFF_FFFF; s.b = 32'd0; s.cy = 1; apply(s, 1);
    s.op = 6'h0C; s.a = 32'h8000_0000; s.b = 32'd0;  apply(s, 1);
    s.op = 6'h27; s.a = 32'h8000_0000; s.b = 32'd4; s.cy = 0; apply(s, 1);
    s.op = 6'h23; s.b = 32'h1234_5000;               apply(s, 1);

    // Window overlap, r0, write enable, wrap-around
    s = idle(); s.cwp = 2'd1; s.rc = 5'd9; s.rin = 32'hA5A5_A5A5; s.rfe = 0; s.ra = 5'd9;
    apply(s, 1);
    s = idle(); s.cwp = 2'd0; s.ra = 5'd25; s.rb = 5'd9; apply(s, 1);
    s = idle(); s.rc = 5'd0; s.rin = 32'hDEAD_BEEF; s.rfe = 0; apply(s, 1);
    s = idle(); apply(s, 1);
    s = idle(); s.cwp = 2'd1; s.rc = 5'd9; s.rin = 32'h1234_5678; s.ra = 5'd9; apply(s, 1);
    apply(s, 1);
    s = idle(); s.cwp = 2'd3; s.rc = 5'd24; s.rin = 32'hCAFE_0001; s.rfe = 0; apply(s, 1);
    s = idle(); s.cwp = 2'd0; s.ra = 5'd8; s.rb = 5'd24; apply(s, 1);
    s.cwp = 2'd3; s.ra = 5'd24;                      apply(s, 1);

    // Reset discards a simultaneous write
    s = idle(); s.rc = 5'd1; s.rin = 32'h1111_1111; s.rfe = 0; apply(s, 1);
    s.cwp = 2'd2; s.rc = 5'd17; s.rin = 32'h2222_2222; apply(s, 1);
    s = idle(); s.cwp = 2'd2; s.ra = 5'd1; s.rb = 5'd17; apply(s, 1);
    s.rst = 1; s.rc = 5'd2; s.rin = 32'h3333_3333; s.rfe = 0; apply(s, 1);
    s = idle(); s.cwp = 2'd2; s.ra = 5'd1; s.rb = 5'd17; apply(s, 1);
    s.ra = 5'd2; s.rb = 5'd25; s.cwp = 2'd3;          apply(s, 1);

    // Trap base
    s = idle(); s.tbx = 32'h1234_5678; apply(s, 1);
    s.tbadd = 1;                       apply(s, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s.a     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      s.b     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      s.op    = 6'($urandom_range(0, 63));
      s.cy    = 1'($urandom_range(0, 1));
      s.alue  = ($urandom_range(0, 7) == 0);
      s.rin   = $urandom;
      s.cwp   = 2'($urandom_range(0, 3));
      s.ra    = 5'($urandom_range(0, 31));
      s.rb    = 5'($urandom_range(0, 31));
      s.rc    = 5'($urandom_range(0, 31));
      s.rfe   = ($urandom_range(0, 3) == 0);
      s.tbx   = $urandom;
      s.tbadd = 1'($urandom_range(0, 1));
      s.rst   = ($urandom_range(0, 63) == 0);
      apply(s, 1);
    end

    repeat (4) @(negedge Clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
